fir_ctrl: RTL
=============

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 8: physical delay-line / coefficient depth (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_W, default 3: log2(NTAPS).
REQ-003 SHALL have parameter MAC_LAT, default 2: MAC pipeline cycles from last mac_en to result valid (0..7).
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 cfg_enable  in  1  accept new samples when 1 (register-file bit).
REQ-007 cfg_ntaps  in  ADDR_W+1  active tap count; 0 or >NTAPS means NTAPS.
REQ-008 cfg_clear  in  1  single-cycle pulse: zero the delay line.
REQ-009 x_valid / x_ready  in / out  1  input sample handshake.
REQ-010 x_we  out  1  delay-line write strobe; x_waddr  out  ADDR_W  write address; x_zero  out  1  write zero instead of sample.
REQ-011 rd_addr  out  ADDR_W  delay-line read address; coef_addr  out  ADDR_W  coefficient address.
REQ-012 mac_clr, mac_en, mac_last  out  1  MAC accumulator clear (with first product), enable, last-tap marker.
REQ-013 y_valid / y_ready  out / in  1  output result handshake.
REQ-014 busy  out  1  state != IDLE; sample_cnt  out  32  completed outputs.

Function
REQ-015 SHALL implement FSM states IDLE, CLR, MAC, WAIT, OUT.
REQ-016 x_ready SHALL be 1 only in IDLE with cfg_enable=1 and no cfg_clear that cycle.
REQ-017 IDLE: cfg_clear=1 -> CLR (priority over x_valid); else x_valid&&x_ready -> x_we=1, x_waddr=wr_ptr (same cycle), latch effective ntaps as N, -> MAC with k=0.
REQ-018 CLR: SHALL assert x_we=1, x_zero=1, x_waddr=0..NTAPS-1 over NTAPS consecutive cycles, then set wr_ptr=0, -> IDLE; cfg_clear in CLR ignored.
REQ-019 MAC: each cycle mac_en=1, coef_addr=k, rd_addr=(wr_ptr-k) mod NTAPS, mac_clr=(k==0), mac_last=(k==N-1); k increments; after k==N-1, wr_ptr<=wr_ptr+1 mod NTAPS, -> WAIT (or OUT if MAC_LAT=0).
REQ-020 WAIT: SHALL hold exactly MAC_LAT cycles, all MAC strobes 0, then -> OUT.
REQ-021 OUT: y_valid=1 held until y_ready; on handshake sample_cnt+=1 (wraps 2^32-1->0), -> IDLE.
REQ-022 Latency: handshake at cycle T -> mac_en cycles T+1..T+N, y_valid first at T+N+MAC_LAT+1; y_ready=1 always gives one result per N+MAC_LAT+2 cycles.
REQ-023 cfg_enable or cfg_ntaps changing mid-sample SHALL NOT affect the sample in flight; cfg_enable=0 only blocks the next accept.
REQ-024 cfg_clear outside IDLE SHALL be dropped (no queuing).
REQ-025 All outputs SHALL be registered-state decodes, glitch-free; x_we and mac_en never both 1.
REQ-026 Address arithmetic SHALL be modulo NTAPS (ADDR_W-bit wrap); N=1 SHALL assert mac_clr and mac_last in the same cycle.

Reset
REQ-027 ARESET=1 at any clock edge SHALL force IDLE, k=0, wr_ptr=0, sample_cnt=0, N=NTAPS, and all outputs 0 on the next cycle, including mid-MAC/OUT (in-flight result discarded).
REQ-028 x_ready SHALL be 0 while ARESET=1; the delay line is not auto-cleared by reset.

Verification
REQ-029 Defaults, cfg_enable=1, cfg_ntaps=0, y_ready=1; x handshake at cycle 10 -> mac_en cycles 11..18, rd_addr 0,7,6,5,4,3,2,1, coef_addr 0..7, mac_clr at 11, mac_last at 18, y_valid at 21, sample_cnt=1.
REQ-030 Nine back-to-back samples -> x_waddr 0..7 then 0, wr_ptr wraps, ninth MAC rd_addr sequence 0,7,...,1; sample_cnt=9.
REQ-031 cfg_ntaps=3, y_ready held 0 for 5 cycles in OUT -> mac_en 3 cycles, y_valid stable 6 cycles, x_ready 0 throughout, one sample_cnt increment.
REQ-032 cfg_clear and x_valid same IDLE cycle -> CLR wins, x_ready=0, x_zero writes addresses 0..7 over 8 cycles, then sample accepted at x_waddr=0.
REQ-033 ARESET pulsed during MAC at k=4 -> next cycle busy=0, mac_en=0, y_valid never asserts, sample_cnt=0, next sample writes x_waddr=0.
REQ-034 cfg_enable dropped during MAC -> current y_valid produced, then x_ready stays 0 until cfg_enable=1.

Source files
------------

// File: rtl/fir_ctrl_if.sv
// Sample-in / MAC-drive / result-out signal bundle for the FIR controller.
// The slave side is the controller; the master side is its environment.
interface fir_ctrl_if #(
   parameter int unsigned ADDR_W = 3
);
   logic              x_valid;
   logic              x_ready;
   logic              x_we;
   logic [ADDR_W-1:0] x_waddr;
   logic              x_zero;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] coef_addr;
   logic              mac_clr;
   logic              mac_en;
   logic              mac_last;
   logic              y_valid;
   logic              y_ready;

   modport master (
      output x_valid, y_ready,
      input  x_ready, x_we, x_waddr, x_zero, rd_addr, coef_addr,
      input  mac_clr, mac_en, mac_last, y_valid
   );

   modport slave (
      input  x_valid, y_ready,
      output x_ready, x_we, x_waddr, x_zero, rd_addr, coef_addr,
      output mac_clr, mac_en, mac_last, y_valid
   );
endinterface

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: accepts a sample into a circular delay line, walks N taps
// through an external MAC, waits out the MAC pipeline and presents one result.
module fir_ctrl #(
   parameter int unsigned NTAPS   = 8,
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              cfg_enable,
   input  logic [ADDR_W:0]   cfg_ntaps,
   input  logic              cfg_clear,
   fir_ctrl_if.slave         bus,
   output logic              busy,
   output logic [31:0]       sample_cnt
);

   typedef enum logic [2:0] {StIdle, StClr, StMac, StWait, StOut} state_e;

   localparam logic [ADDR_W:0]   NTapsW  = (ADDR_W+1)'(NTAPS);
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NTAPS - 1);
   localparam logic [2:0]        LatLast = 3'(MAC_LAT - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] k_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W:0]   n_q;
   logic [2:0]        lat_q;
   logic [ADDR_W:0]   n_eff;
   logic              accept;

   assign n_eff  = (cfg_ntaps == '0 || cfg_ntaps > NTapsW) ? NTapsW : cfg_ntaps;
   assign accept = bus.x_valid && bus.x_ready;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q    <= StIdle;
         k_q        <= '0;
         wr_ptr_q   <= '0;
         n_q        <= NTapsW;
         lat_q      <= '0;
         sample_cnt <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cfg_clear) begin
                  k_q     <= '0;
                  state_q <= StClr;
               end else if (accept) begin
                  n_q     <= n_eff;
                  k_q     <= '0;
                  state_q <= StMac;
               end
            end
            StClr: begin
               if (k_q == LastIdx) begin
                  k_q      <= '0;
                  wr_ptr_q <= '0;
                  state_q  <= StIdle;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            StMac: begin
               if ({1'b0, k_q} == n_q - 1'b1) begin
                  k_q      <= '0;
                  lat_q    <= '0;
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  state_q  <= (MAC_LAT == 0) ? StOut : StWait;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            StWait: begin
               if (lat_q == LatLast) state_q <= StOut;
               else                  lat_q   <= lat_q + 1'b1;
            end
            StOut: begin
               if (bus.y_ready) begin
                  sample_cnt <= sample_cnt + 1'b1;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Accept path is the only input-dependent decode; it is masked during reset.
   assign bus.x_ready   = !ARESET && state_q == StIdle && cfg_enable && !cfg_clear;
   assign bus.x_we      = (state_q == StIdle && accept) || state_q == StClr;
   assign bus.x_zero    = state_q == StClr;
   assign bus.x_waddr   = (state_q == StClr) ? k_q : wr_ptr_q;
   assign bus.mac_en    = state_q == StMac;
   assign bus.coef_addr = (state_q == StMac) ? k_q : '0;
   assign bus.rd_addr   = (state_q == StMac) ? wr_ptr_q - k_q : '0;
   assign bus.mac_clr   = state_q == StMac && k_q == '0;
   assign bus.mac_last  = state_q == StMac && {1'b0, k_q} == n_q - 1'b1;
   assign bus.y_valid   = state_q == StOut;
   assign busy          = state_q != StIdle;

endmodule
